// File: rtl/free_ptr_arbiter_pkg.sv
// Shared definitions for the free-pointer allocator: FSM encodings, default
// geometry and the per-cycle count-update operation.
package free_ptr_arbiter_pkg;

    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_ADDR_WIDTH = 10;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_DEC  = 2'd1,
        CNT_INC  = 2'd2
    } cnt_op_e;

    // Simultaneous allocate and recycle leave the stored count unchanged.
    function automatic cnt_op_e cnt_op(input logic alloc, input logic free_acc);
        cnt_op_e op;
        case ({alloc, free_acc})
            2'b10:   op = CNT_DEC;
            2'b01:   op = CNT_INC;
            default: op = CNT_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/free_ptr_arbiter_fp_ram_sdp.sv
// Simple dual-port pointer storage: one write port, one read port with a
// registered read that clears on reset so the allocated-pointer output starts at 0.
module free_ptr_arbiter_fp_ram_sdp
    import free_ptr_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [ADDR_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [ADDR_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] DATA_ZERO = ADDR_WIDTH'(0);

    logic [ADDR_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_rdata;

    // Storage array write; contents are rebuilt from scratch after every reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read, held between reads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= DATA_ZERO;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/free_ptr_arbiter.sv
// Shared free-pointer allocator: fills its list with every cell address after
// reset, then grants one pointer per cycle round-robin and accepts recycled pointers.
module free_ptr_arbiter
    import free_ptr_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_PORTS-1:0]  i_alloc_req,
    output logic [NUM_PORTS-1:0]  o_alloc_gnt,
    output logic [ADDR_WIDTH-1:0] o_alloc_ptr,
    input  logic                  i_free_vld,
    input  logic [ADDR_WIDTH-1:0] i_free_ptr,
    output logic                  o_free_rdy,
    output logic [ADDR_WIDTH:0]   o_free_cnt,
    output logic                  o_init_done,
    output logic                  o_err_ovf
);

    localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PW1 = PW + 1;
    localparam int CW  = ADDR_WIDTH + 1;

    localparam logic [PW:0]           NP_W      = PW1'(NUM_PORTS);
    localparam logic [PW:0]           IDX_ONE   = PW1'(1);
    localparam logic [PW-1:0]         PRI_ZERO  = PW'(0);
    localparam logic [NUM_PORTS-1:0]  GNT_ONE   = NUM_PORTS'(1);
    localparam logic [NUM_PORTS-1:0]  GNT_NONE  = NUM_PORTS'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = CW'(0);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = CW'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL  = {1'b1, ADDR_ZERO};

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_free_cnt;
    logic [PW-1:0]         r_rr_pri;
    logic [NUM_PORTS-1:0]  r_alloc_gnt;
    logic                  r_init_done;
    logic                  r_err_ovf;

    logic                  w_run;
    logic                  w_empty;
    logic                  w_found;
    logic                  w_hit;
    logic [PW:0]           w_sum;
    logic [PW:0]           w_scan;
    logic [PW-1:0]         w_gnt_idx;
    logic [PW:0]           w_idx_inc;
    logic [PW-1:0]         w_pri_next;
    logic                  w_alloc;
    logic                  w_free_rdy;
    logic                  w_free_acc;
    logic                  w_free_ovf;
    cnt_op_e               w_cnt_op;
    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_waddr;
    logic [ADDR_WIDTH-1:0] w_ram_wdata;
    logic [ADDR_WIDTH-1:0] w_ram_rdata;

    assign w_run   = (r_state == ST_RUN);
    assign w_empty = (r_free_cnt == CNT_ZERO);

    // Rotating priority encoder: scan ports starting at r_rr_pri; the lowest
    // offset wins because it is visited last.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = PRI_ZERO;
        w_sum     = {1'b0, r_rr_pri};
        w_scan    = {1'b0, r_rr_pri};
        w_hit     = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            w_sum     = {1'b0, r_rr_pri} + PW1'(i);
            w_scan    = (w_sum >= NP_W) ? (w_sum - NP_W) : w_sum;
            w_hit     = i_alloc_req[w_scan[PW-1:0]];
            w_found   = w_found | w_hit;
            w_gnt_idx = w_hit ? w_scan[PW-1:0] : w_gnt_idx;
        end
    end

    assign w_idx_inc  = {1'b0, w_gnt_idx} + IDX_ONE;
    assign w_pri_next = (w_idx_inc == NP_W) ? PRI_ZERO : w_idx_inc[PW-1:0];

    // Full/empty come from the count, never from pointer comparison.
    assign w_alloc    = w_run & ~w_empty & w_found;
    assign w_free_rdy = w_run & (r_free_cnt < CNT_FULL);
    assign w_free_acc = i_free_vld & w_free_rdy;
    assign w_free_ovf = w_run & i_free_vld & ~w_free_rdy;

    // Count-update selection for this cycle.
    always_comb begin
        w_cnt_op = cnt_op(w_alloc, w_free_acc);
    end

    // RAM write port: init sequence writes address == data, RUN writes recycled pointers.
    always_comb begin
        if (r_state == ST_INIT) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = r_init_cnt;
            w_ram_wdata = r_init_cnt;
        end else begin
            w_ram_we    = w_free_acc;
            w_ram_waddr = r_wr_ptr;
            w_ram_wdata = i_free_ptr;
        end
    end

    free_ptr_arbiter_fp_ram_sdp #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_alloc),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    // FSM, list pointers, stored count, arbitration priority and error flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= ADDR_ZERO;
            r_wr_ptr    <= ADDR_ZERO;
            r_rd_ptr    <= ADDR_ZERO;
            r_free_cnt  <= CNT_ZERO;
            r_rr_pri    <= PRI_ZERO;
            r_init_done <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    // wr_ptr stays 0: after a full fill it equals rd_ptr + NUM_CELLS.
                    r_init_cnt <= r_init_cnt + ADDR_ONE;
                    r_free_cnt <= r_free_cnt + CNT_ONE;
                    if (r_init_cnt == ADDR_LAST) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_alloc) begin
                        r_rd_ptr <= r_rd_ptr + ADDR_ONE;
                        r_rr_pri <= w_pri_next;
                    end
                    if (w_free_acc) begin
                        r_wr_ptr <= r_wr_ptr + ADDR_ONE;
                    end
                    case (w_cnt_op)
                        CNT_DEC: r_free_cnt <= r_free_cnt - CNT_ONE;
                        CNT_INC: r_free_cnt <= r_free_cnt + CNT_ONE;
                        default: r_free_cnt <= r_free_cnt;
                    endcase
                    if (w_free_ovf) begin
                        r_err_ovf <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // One-hot grant register, aligned with the RAM read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_alloc_gnt <= GNT_NONE;
        end else if (w_alloc) begin
            r_alloc_gnt <= GNT_ONE << w_gnt_idx;
        end else begin
            r_alloc_gnt <= GNT_NONE;
        end
    end

    assign o_alloc_gnt = r_alloc_gnt;
    assign o_alloc_ptr = w_ram_rdata;
    assign o_free_rdy  = w_free_rdy;
    assign o_free_cnt  = r_free_cnt;
    assign o_init_done = r_init_done;
    assign o_err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_free_ptr_arbiter.sv
// Scoreboard bench for free_ptr_arbiter with 4 ports and 16 cells: stimulus queues
// expected {grant, pointer} pairs, a negedge monitor pops them as grants appear.
module tb_free_ptr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] alloc_req;
    logic [3:0] alloc_gnt;
    logic [3:0] alloc_ptr;
    logic       free_vld;
    logic [3:0] free_ptr;
    logic       free_rdy;
    logic [4:0] free_cnt;
    logic       init_done;
    logic       err_ovf;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] ptr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    free_ptr_arbiter #(
        .NUM_PORTS  (4),
        .ADDR_WIDTH (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_alloc_req (alloc_req),
        .o_alloc_gnt (alloc_gnt),
        .o_alloc_ptr (alloc_ptr),
        .i_free_vld  (free_vld),
        .i_free_ptr  (free_ptr),
        .o_free_rdy  (free_rdy),
        .o_free_cnt  (free_cnt),
        .o_init_done (init_done),
        .o_err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_gnt(input logic [3:0] g, input logic [3:0] p);
        exp_t e;
        e.gnt = g;
        e.ptr = p;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented grant must match the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        if (alloc_gnt != 4'b0000) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_gnt: got gnt=%b ptr=%0d, required no grant", alloc_gnt, alloc_ptr);
            end else begin
                e = exp_q.pop_front();
                check("gnt", {28'd0, alloc_gnt}, {28'd0, e.gnt});
                check("gnt_ptr", {28'd0, alloc_ptr}, {28'd0, e.ptr});
            end
        end
    end

    initial begin
        rst       = 1'b1;
        alloc_req = 4'b0000;
        free_vld  = 1'b0;
        free_ptr  = 4'd0;
        repeat (3) tick();

        // Reset state
        check("rst_gnt", {28'd0, alloc_gnt}, 32'd0);
        check("rst_ptr", {28'd0, alloc_ptr}, 32'd0);
        check("rst_cnt", {27'd0, free_cnt}, 32'd0);
        check("rst_rdy", {31'd0, free_rdy}, 32'd0);
        check("rst_done", {31'd0, init_done}, 32'd0);
        check("rst_err", {31'd0, err_ovf}, 32'd0);

        // Test 1: init fill; requests held during INIT must not be granted
        rst       = 1'b0;
        alloc_req = 4'b1111;
        repeat (15) tick();
        check("init_cnt15", {27'd0, free_cnt}, 32'd15);
        check("init_done_early", {31'd0, init_done}, 32'd0);
        check("init_rdy", {31'd0, free_rdy}, 32'd0);
        tick();
        alloc_req = 4'b0000;
        check("init_done", {31'd0, init_done}, 32'd1);
        check("init_cnt16", {27'd0, free_cnt}, 32'd16);
        check("full_rdy", {31'd0, free_rdy}, 32'd0);

        // Test 2: single request from port 0
        alloc_req = 4'b0001;
        expect_gnt(4'b0001, 4'd0);
        tick();
        alloc_req = 4'b0000;
        check("t2_cnt", {27'd0, free_cnt}, 32'd15);
        check("t2_rdy", {31'd0, free_rdy}, 32'd1);

        // Test 3: port 3 once (priority back to 0), then all ports held
        alloc_req = 4'b1000;
        expect_gnt(4'b1000, 4'd1);
        tick();
        alloc_req = 4'b1111;
        expect_gnt(4'b0001, 4'd2);
        expect_gnt(4'b0010, 4'd3);
        expect_gnt(4'b0100, 4'd4);
        expect_gnt(4'b1000, 4'd5);
        expect_gnt(4'b0001, 4'd6);
        repeat (5) tick();
        alloc_req = 4'b0000;
        check("t3_cnt", {27'd0, free_cnt}, 32'd9);

        // Test 5a: down to 8, then simultaneous alloc + free holds the count
        alloc_req = 4'b0010;
        expect_gnt(4'b0010, 4'd7);
        tick();
        check("t5_cnt8", {27'd0, free_cnt}, 32'd8);
        alloc_req = 4'b0100;
        free_vld  = 1'b1;
        free_ptr  = 4'd0;
        expect_gnt(4'b0100, 4'd8);
        tick();
        alloc_req = 4'b0000;
        free_vld  = 1'b0;
        check("t5_both_cnt", {27'd0, free_cnt}, 32'd8);

        // Test 4: drain the list (priority at port 3), then wait on empty
        alloc_req = 4'b1111;
        expect_gnt(4'b1000, 4'd9);
        expect_gnt(4'b0001, 4'd10);
        expect_gnt(4'b0010, 4'd11);
        expect_gnt(4'b0100, 4'd12);
        expect_gnt(4'b1000, 4'd13);
        expect_gnt(4'b0001, 4'd14);
        expect_gnt(4'b0010, 4'd15);
        expect_gnt(4'b0100, 4'd0);
        repeat (8) tick();
        alloc_req = 4'b0100;
        check("t4_empty_cnt", {27'd0, free_cnt}, 32'd0);
        repeat (3) tick();
        check("t4_empty_gnt", {28'd0, alloc_gnt}, 32'd0);
        check("t4_empty_cnt2", {27'd0, free_cnt}, 32'd0);
        check("t4_empty_rdy", {31'd0, free_rdy}, 32'd1);
        free_vld = 1'b1;
        free_ptr = 4'd7;
        expect_gnt(4'b0100, 4'd7);
        tick();
        free_vld = 1'b0;
        check("t4_no_bypass", {28'd0, alloc_gnt}, 32'd0);
        check("t4_cnt1", {27'd0, free_cnt}, 32'd1);
        tick();
        alloc_req = 4'b0000;
        check("t4_cnt_after", {27'd0, free_cnt}, 32'd0);

        // Test 5b: refill all 16 with a permutation, then overflow attempt
        for (int i = 0; i < 16; i++) begin
            free_vld = 1'b1;
            free_ptr = 4'((i * 5) % 16);
            if (i == 0 || i == 15) begin
                check("t5_fill_rdy", {31'd0, free_rdy}, 32'd1);
            end
            tick();
        end
        check("t5_full_cnt", {27'd0, free_cnt}, 32'd16);
        check("t5_full_rdy", {31'd0, free_rdy}, 32'd0);
        check("t5_err_pre", {31'd0, err_ovf}, 32'd0);
        free_ptr = 4'd3;
        tick();
        free_vld = 1'b0;
        check("t5_err_set", {31'd0, err_ovf}, 32'd1);
        check("t5_ovf_cnt", {27'd0, free_cnt}, 32'd16);
        tick();
        check("t5_err_sticky", {31'd0, err_ovf}, 32'd1);

        // Recycled pointers come back in free order
        alloc_req = 4'b0001;
        expect_gnt(4'b0001, 4'd0);
        expect_gnt(4'b0001, 4'd5);
        expect_gnt(4'b0001, 4'd10);
        repeat (3) tick();
        alloc_req = 4'b0000;
        check("t5_cnt13", {27'd0, free_cnt}, 32'd13);
        check("t5_err_hold", {31'd0, err_ovf}, 32'd1);

        // Test 6: reset in the middle of a burst
        alloc_req = 4'b1111;
        expect_gnt(4'b0010, 4'd15);
        tick();
        rst = 1'b1;
        tick();
        check("t6_gnt", {28'd0, alloc_gnt}, 32'd0);
        check("t6_ptr", {28'd0, alloc_ptr}, 32'd0);
        check("t6_cnt", {27'd0, free_cnt}, 32'd0);
        check("t6_done", {31'd0, init_done}, 32'd0);
        check("t6_err", {31'd0, err_ovf}, 32'd0);
        check("t6_rdy", {31'd0, free_rdy}, 32'd0);
        rst = 1'b0;
        repeat (15) tick();
        check("t6_done_early", {31'd0, init_done}, 32'd0);
        tick();
        alloc_req = 4'b0000;
        check("t6_done", {31'd0, init_done}, 32'd1);
        check("t6_cnt16", {27'd0, free_cnt}, 32'd16);
        alloc_req = 4'b0001;
        expect_gnt(4'b0001, 4'd0);
        tick();
        alloc_req = 4'b0000;
        repeat (3) tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
